rv32i_lsu: RTL



---
 rtl/rv32i_lsu.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - RV32I load/store unit bridging the core to a valid/ready memory bus
//
// Converts byte/half/word loads and stores into word-aligned bus transactions
// with byte enables, returns sign/zero-extended load data, and stalls the core
// until the access completes, faults (misaligned / illegal funct3) or times out.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req_*               core request (valid, we, funct3, addr, wdata), held while stall=1
//   stall               core must hold its request (combinational)
//   resp_valid/rdata    one-cycle completion pulse with extended load data
//   misaligned, bus_err fault flags, pulsed alongside resp_valid
//   mem_req_*/mem_*     bus request channel (valid/ready, addr, we, be, wdata)
//   mem_rsp_*           bus response channel (valid, rdata)

module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  logic        fault;
  logic [3:0]  be_req;
  logic [31:0] wdata_rep;
  logic [16:0] cnt_inc;
  logic        expire;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Request decode: fault detection, byte enables and lane-replicated store data.
  always_comb begin
    // 011/110/111 are not loads or stores; BU/HU (funct3[2]=1) are load-only.
    fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
            (req_we && req_funct3[2]) ||
            (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_funct3[1:0])
      2'b00: begin
        be_req    = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_req    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        be_req    = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane = mem_rsp_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  // The counter value after this cycle; reaching the limit aborts the access.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign expire  = (cnt_inc == TMO);

  always_comb begin
    state_d         = state_q;
    cnt_d           = 16'd0;
    f3_d            = f3_q;
    off_d           = off_q;
    mem_req_valid_d = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_we_d        = mem_we_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = 32'd0;
    misaligned_d    = 1'b0;
    bus_err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (fault) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            f3_d            = req_funct3;
            off_d           = req_addr[1:0];
            mem_addr_d      = {req_addr[31:2], 2'b00};
            mem_we_d        = req_we;
            mem_be_d        = be_req;
            mem_wdata_d     = wdata_rep;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc[15:0];
        // A ready in the final cycle still completes the handshake.
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (expire) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[15:0];
        if (mem_rsp_valid) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? 32'd0 : load_data;
        end else if (expire) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
        end
      end
      default: begin
        // DONE lasts exactly one cycle; the held request is not re-accepted here.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 16'd0;
      f3_q            <= 3'd0;
      off_q           <= 2'd0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'd0;
      mem_wdata_q     <= 32'd0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      misaligned_q    <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      misaligned_q    <= misaligned_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign stall         = req_valid && (state_q != S_DONE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign misaligned    = misaligned_q;
  assign bus_err       = bus_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
